// File: rtl/data_sync_arb_pkg.sv
// data_sync_arb_pkg
// Shared definitions for the data_sync_arb slice: the sequencer state
// encoding and the width helpers used for the owner index and the WAIT
// cycle counter.
package data_sync_arb_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    // Width of an index that addresses n requesters (at least one bit).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that can hold the value t without wrapping.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/data_sync_arb_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Searches req upward starting at
// last+1 and wrapping modulo N_REQ; the first set bit wins.
// Ports:
//   req   in  N_REQ  request vector
//   last  in  ID_W   index of the previous owner
//   valid out 1      any request present
//   idx   out ID_W   selected requester (0 when valid is low)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    // Walk the offsets from farthest to nearest so the nearest set bit
    // after last is the one that sticks.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = req[(int'(last) + i) % N_REQ] ? ID_W'((int'(last) + i) % N_REQ) : idx;
        end
    end

endmodule

// File: rtl/data_sync_arb.sv
// data_sync_arb
// Round-robin arbiter/sequencer sharing one data_sync CDC channel between
// N_REQ requesters in the sclk domain. A winner's word is latched, a
// single-cycle sync_start is issued, the word is held through WAIT until
// sync_done (or a timeout), then one GAP cycle precedes the next pick.
// Optional feature macro: DATA_SYNC_ARB_TIMEOUT_EN (WAIT counter and
// timeout_err abort path; without it WAIT exits only on sync_done).
// Ports:
//   sclk          in   source clock
//   resetn        in   asynchronous active-low reset
//   req           in   N_REQ request levels, held until gnt
//   req_data      in   N_REQ*WIDTH words, requester i at [i*WIDTH +: WIDTH]
//   gnt           out  one-hot one-cycle grant pulse (during START)
//   src_id        out  index of current/last owner
//   sync_start    out  one-cycle start pulse to data_sync
//   sync_data_out out  word to data_sync, stable START..WAIT
//   sync_done     in   completion pulse, already in sclk domain
//   busy          out  high whenever the sequencer is not IDLE
//   timeout_err   out  one-cycle pulse on WAIT abort
module data_sync_arb
    import data_sync_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     sclk,
    input  logic                     resetn,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [id_width(N_REQ)-1:0] src_id,
    output logic                     sync_start,
    output logic [WIDTH-1:0]         sync_data_out,
    input  logic                     sync_done,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int ID_W = id_width(N_REQ);

    arb_state_e         state_r, state_nx;
    logic [N_REQ-1:0]   gnt_r, gnt_nx;
    logic               start_r, start_nx;
    logic [WIDTH-1:0]   data_r, data_nx;
    logic [ID_W-1:0]    id_r, id_nx;
    logic [ID_W-1:0]    last_r, last_nx;
    logic               busy_r, busy_nx;
    logic               pick_valid_s;
    logic [ID_W-1:0]    pick_idx_s;

`ifdef DATA_SYNC_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT);
    logic [CNT_W-1:0]   cnt_r, cnt_nx;
    logic               terr_r, terr_nx;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_nx = state_r;
        gnt_nx   = '0;
        start_nx = 1'b0;
        data_nx  = data_r;
        id_nx    = id_r;
        last_nx  = last_r;
        busy_nx  = busy_r;
`ifdef DATA_SYNC_ARB_TIMEOUT_EN
        cnt_nx   = cnt_r;
        terr_nx  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    // Grant and start are registered so they appear
                    // together during the START cycle.
                    state_nx = START;
                    data_nx  = req_data[pick_idx_s*WIDTH +: WIDTH];
                    id_nx    = pick_idx_s;
                    last_nx  = pick_idx_s;
                    gnt_nx   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    start_nx = 1'b1;
                    busy_nx  = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            START: begin
                state_nx = WAIT;
`ifdef DATA_SYNC_ARB_TIMEOUT_EN
                cnt_nx   = '0;
`endif
            end
            WAIT: begin
`ifdef DATA_SYNC_ARB_TIMEOUT_EN
                // Saturate rather than wrap; the abort fires well before.
                cnt_nx = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
                if (sync_done) begin
                    state_nx = GAP;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = GAP;
                    terr_nx  = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
`else
                if (sync_done) begin
                    state_nx = GAP;
                end else begin
                    state_nx = WAIT;
                end
`endif
            end
            GAP: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            start_r <= 1'b0;
            data_r  <= '0;
            id_r    <= '0;
            last_r  <= ID_W'(N_REQ - 1);
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            gnt_r   <= gnt_nx;
            start_r <= start_nx;
            data_r  <= data_nx;
            id_r    <= id_nx;
            last_r  <= last_nx;
            busy_r  <= busy_nx;
        end
    end

`ifdef DATA_SYNC_ARB_TIMEOUT_EN
    // WAIT cycle counter and abort pulse.
    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            cnt_r  <= '0;
            terr_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nx;
            terr_r <= terr_nx;
        end
    end

    assign timeout_err = terr_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign gnt           = gnt_r;
    assign sync_start    = start_r;
    assign sync_data_out = data_r;
    assign src_id        = id_r;
    assign busy          = busy_r;

endmodule

// File: doc/data_sync_arb.md
# data_sync_arb

Round-robin arbiter and sequencer that shares a single `data_sync` clock-domain-crossing channel between `N_REQ` requesters in the source (`sclk`) domain. It selects one requester, latches its word, issues a single-cycle `start` to `data_sync`, and holds the word stable until the returned completion pulse arrives or a timeout expires. It then enforces an idle gap before the next transfer. The block sits in the `sclk` domain, directly in front of `data_sync`.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, data word width, matches `data_sync.WIDTH`
- `TIMEOUT`, 15, maximum number of WAIT cycles before abort (≥1)

Ports:
- `sclk`  in  1  source clock; the block's only clock
- `resetn`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request level; held until its `gnt`
- `req_data`  in  N_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- `gnt`  out  N_REQ  one-hot, one-cycle pulse; the word is accepted
- `src_id`  out  $clog2(N_REQ)  index of the current or last owner
- `sync_start`  out  1  to `data_sync.start`; one-cycle pulse
- `sync_data_out`  out  WIDTH  to `data_sync.data`; stable from START through WAIT
- `sync_done`  in  1  completion pulse from the return path, already synchronised to `sclk`
- `busy`  out  1  high whenever state ≠ IDLE
- `timeout_err`  out  1  one-cycle pulse on abort

## Operation
- FSM states: IDLE, START, WAIT, GAP. All outputs are registered.
- **IDLE:**
  - If `req` ≠ 0, pick the first set bit searching upward from `last+1`, wrapping modulo N_REQ.
  - Latch `req_data` slice into `sync_data_out`, set `src_id` and `last`, then go to START.
  - If `req` = 0, stay in IDLE.
- **START** (exactly 1 cycle):
  - `gnt[src_id]` = 1 and `sync_start` = 1.
  - Clear the counter and go to WAIT.
- **WAIT:**
  - Counter increments each cycle. `sync_data_out` is frozen.
  - `sync_done` = 1 → GAP.
  - Else, if counter = TIMEOUT-1 → GAP and pulse `timeout_err` (only when the macro is defined).
- **GAP** (exactly 1 cycle): go to IDLE. This guarantees that consecutive `sync_start` pulses are at least 4 cycles apart.
- `sync_done` in IDLE, START or GAP is ignored.
- A requester that keeps `req` high after its `gnt` is treated as a new request. It waits for its next round-robin turn.
- `req` dropping before grant: the request is withdrawn, with no side effect.
- Reset values:
  - State IDLE; `gnt`, `sync_start`, `busy`, `timeout_err`, `sync_data_out`, `src_id` = 0.
  - `last` = N_REQ-1, so requester 0 has first priority.
  - Counter = 0.
- **Reset mid-transfer:** the in-flight transfer is discarded, with no `gnt` or `timeout_err` emitted. `data_sync` recovery is the system's responsibility.

## Timing
- `req` sampled high in IDLE at edge n → START (`gnt`, `sync_start`) during cycle n+1 → first WAIT cycle n+2.
- `sync_done` sampled in WAIT at edge k → GAP in cycle k+1, IDLE in k+2.
- Earliest next `sync_start` is cycle k+3.
- Timeout: no `sync_done` in the TIMEOUT WAIT cycles starting at w → `timeout_err` and GAP in cycle w+TIMEOUT.
- `sync_done` on the last WAIT cycle takes precedence: completion, no error.
- `busy` rises the cycle START begins and falls the cycle IDLE is re-entered.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Configuration
- `DATA_SYNC_ARB_TIMEOUT_EN`:
  - **Defined:** counter and timeout path exist as above.
  - **Undefined:** WAIT exits only on `sync_done`, `timeout_err` is constant 0, and the counter logic is removed.

## Structure
- Package `data_sync_arb_pkg` holds:
  - the state enum (IDLE, START, WAIT, GAP);
  - width helper constants for `src_id` and the counter.
- Sub-module `rr_pick`: combinational round-robin selector with inputs `req`, `last` and outputs `valid`, `idx`. It is instantiated once.

## Test plan
All scenarios use N_REQ=4, WIDTH=8, TIMEOUT=15, with `DATA_SYNC_ARB_TIMEOUT_EN` defined unless stated.
- **Single request:** `req`=0001, slice0=0x0A, `sync_done` 5 cycles after `sync_start` → `gnt`=0001 and `sync_start` 1 cycle after `req`, `sync_data_out`=0x0A stable until GAP, `busy` low 2 cycles after `sync_done`.
- **Round robin:** `req`=1111 held, with `sync_done` returned each transfer → grant order 0,1,2,3,0; each `src_id` matches its `gnt` index.
- **Timeout:** `req`=0100, no `sync_done` → `timeout_err` pulse exactly 15 cycles after the first WAIT cycle, then IDLE. A following `req`=0001 is served normally.
- **Boundary:** `sync_done` on the 15th WAIT cycle → no `timeout_err`. A stray `sync_done` in IDLE → no state change.
- **Reset mid-WAIT:** assert `resetn`=0 asynchronously during WAIT → all outputs 0 immediately. After release, `req`=1001 → requester 0 granted first.
- **Macro undefined:** no `sync_done` for 100 cycles → stays in WAIT, `timeout_err` is never asserted.
